fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- PC register plus instruction-bus request FSM for the fetch stage of the RV64 pipeline.
- Holds the architectural fetch PC and drives the 32-bit instruction bus.
- Buffers one returned instruction and hands {pc, instr} to the F/D pipeline register through a valid/ready handshake.
- Closes the loop with the PC selector: supplies pc+4 and the stall indication, and loads the selector's result back into the PC.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- pc_selected  in  64  next PC from the PC selector.
- pcplus4  out  64  pc+4, fed to the PC selector.
- stall_f  out  1  to the PC selector; high whenever the current instruction is not being handed off.
- redirect_valid  in  1  branch/jump redirect from execute.
- redirect_pc  in  64  redirect target.
- ireq_valid  out  1  instruction-bus request valid.
- ireq_addr  out  64  instruction-bus request address.
- iresp_data_ok  in  1  response valid; completes the outstanding request.
- iresp_data  in  32  fetched instruction.
- d_valid  out  1  instruction available to decode.
- d_pc  out  64  PC of that instruction.
- d_instr  out  32  instruction word.
- d_misalign  out  1  pc[1:0] != 0; no bus access was made for this instruction.
- d_ready  in  1  decode accepts the instruction this cycle.

Behaviour:
- Registers:
  - pc (64)
  - req_addr (64): address of the outstanding bus request
  - ibuf (32)
  - mis (1)
  - state ∈ {IDLE, REQ, DRAIN, OUT}
- Reset (reset==0 at a clock edge):
  - pc=RESET_PC, state=IDLE, ibuf=0, mis=0.
  - Any outstanding bus request is abandoned.
  - Takes precedence over every other event, including mid-request.
- Outputs while in reset: ireq_valid=0, d_valid=0, ireq_addr=0, d_instr=0, d_misalign=0. d_pc and pcplus4 track pc.
- Combinational outputs:
  - pcplus4 = pc + 64'd4, modulo 2^64; wraps at 64'hFFFF_FFFF_FFFF_FFFC to 0.
  - handoff = (state==OUT) && d_ready && !redirect_valid.
  - stall_f = !handoff.
  - d_valid = (state==OUT) && !redirect_valid.
  - d_pc = pc, d_instr = ibuf, d_misalign = mis.
  - ireq_valid = (state==REQ && pc[1:0]==0) || state==DRAIN.
  - ireq_addr = pc in REQ, req_addr in DRAIN, 0 otherwise.
- PC update, every cycle:
  - If redirect_valid: pc <= redirect_pc.
  - Else: pc <= pc_selected. While stall_f=1 the selector returns pcplus4-4 = pc, so pc holds.
- Bus rule: once ireq_valid rises, ireq_valid and ireq_addr stay stable until the cycle iresp_data_ok=1. Exactly one request is outstanding.
- FSM:
  - IDLE → REQ (one cycle after reset release).
  - REQ, pc[1:0]!=0: no request issued; ibuf <= 32'h0000_0013, mis <= 1, go to OUT.
  - REQ, data_ok=1, no redirect: ibuf <= iresp_data, mis <= 0, go to OUT.
  - REQ, data_ok=1, redirect: discard the data, stay in REQ (the new pc is requested next cycle).
  - REQ, data_ok=0, redirect: req_addr <= pc, go to DRAIN.
  - REQ, otherwise: stay in REQ.
  - DRAIN: wait for data_ok, discard the data, go to REQ. A further redirect while in DRAIN only updates pc.
  - OUT, redirect: go to REQ; the instruction is killed.
  - OUT, handoff: go to REQ.
  - OUT, otherwise: hold; ibuf, mis and pc stay stable.
- Latency: data_ok in cycle N gives d_valid in cycle N+1. Peak throughput is one instruction per 2 cycles.
- Redirect and d_ready together: redirect wins and no handoff occurs.

Optional Feature:
- FETCH_PERF_EN defined: adds two outputs.
  - perf_fetched (64): increments on each handoff.
  - perf_stall (64): increments each cycle ireq_valid=1 && !iresp_data_ok.
  - Both clear on reset and wrap modulo 2^64.
- Not defined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset release, d_ready=1, bus answers data_ok on the 1st request cycle with 32'h0000_0093 → ireq_addr=0x8000_0000; d_valid with d_pc=0x8000_0000, d_instr=0x0000_0093 one cycle later; next request at 0x8000_0004.
- d_ready=0 for 5 cycles while in OUT → d_valid, d_pc and d_instr stable, stall_f=1, pc unchanged. Raising d_ready gives exactly one handoff.
- redirect_valid=1, redirect_pc=0x8000_0100 while REQ is waiting (data_ok delayed 3 cycles) → ireq_addr stays 0x8000_0000 until data_ok; that data is dropped; next request is 0x8000_0100; d_valid never shows the dropped word.
- Redirect in the same cycle as d_ready in OUT → no handoff, d_valid=0 that cycle, next fetch at redirect_pc.
- redirect_pc=0x8000_0102 → no bus request; d_valid with d_misalign=1, d_instr=0x0000_0013, d_pc=0x8000_0102.
- reset asserted while DRAIN is waiting for data_ok → next cycle state=IDLE, ireq_valid=0, pc=RESET_PC; a late data_ok is ignored.

Source files
------------

// File: rtl/fetch_unit.sv
// Fetch stage of the RV64 pipeline: PC register, instruction-bus request FSM and
// one-entry instruction buffer for the F/D handoff. Optional counters: FETCH_PERF_EN.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] pc_selected,
  output logic [63:0] pcplus4,
  output logic        stall_f,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        d_valid,
  output logic [63:0] d_pc,
  output logic [31:0] d_instr,
  output logic        d_misalign,
  input  logic        d_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [63:0] perf_fetched,
  output logic [63:0] perf_stall
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, OUT} state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  state_t      state;
  state_t      state_next;
  logic [63:0] pc;
  logic [63:0] req_addr;
  logic [63:0] req_addr_next;
  logic [31:0] ibuf;
  logic [31:0] ibuf_next;
  logic        mis;
  logic        mis_next;
  logic        pc_misaligned;
  logic        handoff;

  assign pc_misaligned = (pc[1:0] != 2'b00);

  // Outputs are gated by reset so nothing leaks onto the bus or into decode
  // while reset is held low, regardless of the state left over.
  always_comb begin
    pcplus4    = pc + 64'd4;
    d_pc       = pc;
    d_valid    = reset && (state == OUT) && !redirect_valid;
    handoff    = d_valid && d_ready;
    stall_f    = !handoff;
    d_instr    = reset ? ibuf : 32'h0;
    d_misalign = reset ? mis : 1'b0;
    ireq_valid = 1'b0;
    ireq_addr  = 64'h0;
    if (reset) begin
      case (state)
        REQ: begin
          ireq_valid = !pc_misaligned;
          ireq_addr  = pc;
        end
        DRAIN: begin
          ireq_valid = 1'b1;
          ireq_addr  = req_addr;
        end
        default: begin
          ireq_valid = 1'b0;
          ireq_addr  = 64'h0;
        end
      endcase
    end
  end

  // Next-state logic. In REQ a redirect takes priority over the misaligned
  // shortcut so a stale PC never produces a synthetic instruction.
  always_comb begin
    state_next    = state;
    req_addr_next = req_addr;
    ibuf_next     = ibuf;
    mis_next      = mis;
    case (state)
      IDLE: state_next = REQ;
      REQ: begin
        if (redirect_valid) begin
          if (!pc_misaligned && !iresp_data_ok) begin
            req_addr_next = pc;
            state_next    = DRAIN;
          end else begin
            state_next = REQ;
          end
        end else if (pc_misaligned) begin
          ibuf_next  = NOP_INSTR;
          mis_next   = 1'b1;
          state_next = OUT;
        end else if (iresp_data_ok) begin
          ibuf_next  = iresp_data;
          mis_next   = 1'b0;
          state_next = OUT;
        end
      end
      DRAIN: begin
        if (iresp_data_ok) state_next = REQ;
      end
      OUT: begin
        if (redirect_valid || handoff) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  // While stalled the selector feeds back pc itself, so pc holds without a hold mux here.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc       <= RESET_PC;
      state    <= IDLE;
      req_addr <= 64'h0;
      ibuf     <= 32'h0;
      mis      <= 1'b0;
    end else begin
      pc       <= redirect_valid ? redirect_pc : pc_selected;
      state    <= state_next;
      req_addr <= req_addr_next;
      ibuf     <= ibuf_next;
      mis      <= mis_next;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_fetched <= 64'h0;
      perf_stall   <= 64'h0;
    end else begin
      if (handoff) perf_fetched <= perf_fetched + 64'd1;
      if (ireq_valid && !iresp_data_ok) perf_stall <= perf_stall + 64'd1;
    end
  end
`else
  // Performance counters not built.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit; a small PC-selector model closes the pc loop.
module tb_fetch_unit;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        reset;
  logic [63:0] pc_selected;
  logic [63:0] pcplus4;
  logic        stall_f;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        d_valid;
  logic [63:0] d_pc;
  logic [31:0] d_instr;
  logic        d_misalign;
  logic        d_ready;
`ifdef FETCH_PERF_EN
  logic [63:0] perf_fetched;
  logic [63:0] perf_stall;
`endif

  int checks = 0;
  int errors = 0;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .pc_selected    (pc_selected),
    .pcplus4        (pcplus4),
    .stall_f        (stall_f),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .d_valid        (d_valid),
    .d_pc           (d_pc),
    .d_instr        (d_instr),
    .d_misalign     (d_misalign),
    .d_ready        (d_ready)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  // PC selector model: sequential pc+4 when the instruction leaves, hold otherwise.
  assign pc_selected = stall_f ? (pcplus4 - 64'd4) : pcplus4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1, "[TB] simulation time limit expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rst, input logic rv, input logic [63:0] rpc,
                               input logic ok, input logic [31:0] data, input logic rdy);
    reset          = rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    iresp_data_ok  = ok;
    iresp_data     = data;
    d_ready        = rdy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();

    // Reset state
    checkOutput("rst_ireq_valid", ireq_valid, 1'b0);
    checkOutput("rst_ireq_addr", ireq_addr, 64'h0);
    checkOutput("rst_d_valid", d_valid, 1'b0);
    checkOutput("rst_d_instr", d_instr, 32'h0);
    checkOutput("rst_d_misalign", d_misalign, 1'b0);
    checkOutput("rst_d_pc", d_pc, RESET_PC);
    checkOutput("rst_pcplus4", pcplus4, RESET_PC + 64'd4);
    checkOutput("rst_stall_f", stall_f, 1'b1);

    // Release: one IDLE cycle, then request at RESET_PC answered immediately
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b0, 32'h0, 1'b1);
    checkOutput("idle_ireq_valid", ireq_valid, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b1, 32'h0000_0093, 1'b1);
    checkOutput("t1_ireq_valid", ireq_valid, 1'b1);
    checkOutput("t1_ireq_addr", ireq_addr, 64'h8000_0000);
    checkOutput("t1_stall_req", stall_f, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b0, 32'h0, 1'b1);
    checkOutput("t1_d_valid", d_valid, 1'b1);
    checkOutput("t1_d_pc", d_pc, 64'h8000_0000);
    checkOutput("t1_d_instr", d_instr, 32'h0000_0093);
    checkOutput("t1_d_misalign", d_misalign, 1'b0);
    checkOutput("t1_stall_handoff", stall_f, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b1, 32'h0010_0113, 1'b0);
    checkOutput("t1_next_addr", ireq_addr, 64'h8000_0004);
    checkOutput("t1_next_valid", ireq_valid, 1'b1);
    checkOutput("t1_next_d_valid", d_valid, 1'b0);
    tick();

    // Decode back-pressure for 5 cycles
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("t2_hold_d_valid", d_valid, 1'b1);
      checkOutput("t2_hold_d_pc", d_pc, 64'h8000_0004);
      checkOutput("t2_hold_d_instr", d_instr, 32'h0010_0113);
      checkOutput("t2_hold_stall", stall_f, 1'b1);
      tick();
    end
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b0, 32'h0, 1'b1);
    checkOutput("t2_release_stall", stall_f, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b0, 32'h0, 1'b1);
    checkOutput("t2_one_handoff_pc", d_pc, 64'h8000_0008);
    checkOutput("t2_one_handoff_valid", d_valid, 1'b0);
    tick();
    checkOutput("t2_pc_holds_in_req", d_pc, 64'h8000_0008);

    // Re-reset, then redirect while the first request is outstanding
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 64'h8000_0100, 1'b0, 32'h0, 1'b0);
    checkOutput("t3_req_addr", ireq_addr, 64'h8000_0000);
    checkOutput("t3_req_valid", ireq_valid, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("t3_drain_addr0", ireq_addr, 64'h8000_0000);
    checkOutput("t3_drain_valid0", ireq_valid, 1'b1);
    checkOutput("t3_drain_pc", d_pc, 64'h8000_0100);
    tick();
    checkOutput("t3_drain_addr1", ireq_addr, 64'h8000_0000);
    checkOutput("t3_drain_d_valid", d_valid, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    checkOutput("t3_drain_addr2", ireq_addr, 64'h8000_0000);
    tick();
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("t3_dropped_d_valid", d_valid, 1'b0);
    checkOutput("t3_new_addr", ireq_addr, 64'h8000_0100);
    checkOutput("t3_new_valid", ireq_valid, 1'b1);
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b1, 32'h0000_0513, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("t3_d_valid", d_valid, 1'b1);
    checkOutput("t3_d_instr", d_instr, 32'h0000_0513);
    checkOutput("t3_d_pc", d_pc, 64'h8000_0100);

    // Redirect together with d_ready in OUT
    applyStimulus(1'b1, 1'b1, 64'h8000_0200, 1'b0, 32'h0, 1'b1);
    checkOutput("t4_d_valid", d_valid, 1'b0);
    checkOutput("t4_stall", stall_f, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("t4_next_addr", ireq_addr, 64'h8000_0200);
    checkOutput("t4_next_valid", ireq_valid, 1'b1);
    checkOutput("t4_next_d_valid", d_valid, 1'b0);

    // Misaligned redirect target
    applyStimulus(1'b1, 1'b1, 64'h8000_0102, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b1, 32'h1234_5678, 1'b0);
    checkOutput("t5_drain_addr", ireq_addr, 64'h8000_0200);
    tick();
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("t5_no_request", ireq_valid, 1'b0);
    tick();
    checkOutput("t5_no_request_out", ireq_valid, 1'b0);
    checkOutput("t5_d_valid", d_valid, 1'b1);
    checkOutput("t5_d_misalign", d_misalign, 1'b1);
    checkOutput("t5_d_instr", d_instr, 32'h0000_0013);
    checkOutput("t5_d_pc", d_pc, 64'h8000_0102);

    // Reset while DRAIN waits for data_ok
    applyStimulus(1'b1, 1'b1, 64'h8000_0300, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 64'h8000_0400, 1'b0, 32'h0, 1'b0);
    checkOutput("t6_req_addr", ireq_addr, 64'h8000_0300);
    tick();
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("t6_drain_addr", ireq_addr, 64'h8000_0300);
    checkOutput("t6_drain_valid", ireq_valid, 1'b1);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("t6_inrst_valid", ireq_valid, 1'b0);
    checkOutput("t6_inrst_addr", ireq_addr, 64'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b1, 32'h0000_0BAD, 1'b1);
    checkOutput("t6_idle_valid", ireq_valid, 1'b0);
    checkOutput("t6_idle_pc", d_pc, RESET_PC);
    tick();
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b0, 32'h0, 1'b1);
    checkOutput("t6_req_after_rst", ireq_addr, 64'h8000_0000);
    checkOutput("t6_late_ok_ignored", d_valid, 1'b0);
    tick();
    checkOutput("t6_still_waiting", d_valid, 1'b0);
    checkOutput("t6_still_valid", ireq_valid, 1'b1);

    // pcplus4 wraps at the top of the address space
    applyStimulus(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("wrap_pc", d_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("wrap_pcplus4", pcplus4, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
